// File: rtl/udma_ctrl_evt_mc.sv
// uDMA control block: peripheral clock gates and resets (level and self-timed pulse),
// plus masked event-compare channels with sticky read-to-clear status and interrupt.
module udma_ctrl_evt_mc #(
    parameter int unsigned N_PERIPHS = 6,
    parameter int unsigned N_EVT_CMP = 4,
    parameter int unsigned RST_LEN   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cfg_data_i,
    input  logic [4:0]           cfg_addr_i,
    input  logic                 cfg_valid_i,
    input  logic                 cfg_rwn_i,
    output logic [31:0]          cfg_data_o,
    output logic                 cfg_ready_o,
    output logic [N_PERIPHS-1:0] rst_value_o,
    output logic [N_PERIPHS-1:0] cg_value_o,
    output logic                 cg_core_o,
    input  logic                 event_valid_i,
    input  logic [7:0]           event_data_i,
    output logic                 event_ready_o,
    output logic [N_EVT_CMP-1:0] event_o,
    output logic                 evt_irq_o
);

    localparam int unsigned N_CFG_WORDS = N_EVT_CMP / 4;

    localparam logic [4:0] ADDR_CG         = 5'h00;
    localparam logic [4:0] ADDR_CG_SET     = 5'h01;
    localparam logic [4:0] ADDR_CG_CLR     = 5'h02;
    localparam logic [4:0] ADDR_RST        = 5'h03;
    localparam logic [4:0] ADDR_RST_PULSE  = 5'h04;
    localparam logic [4:0] ADDR_EVT_STATUS = 5'h05;
    localparam logic [4:0] ADDR_EVT_MASK   = 5'h06;
    localparam logic [4:0] ADDR_CFG_EVT    = 5'h08;

    logic [N_PERIPHS-1:0] r_cg;
    logic [N_PERIPHS-1:0] r_rst;
    logic [N_PERIPHS-1:0] busy;
    logic [7:0]           cnt [N_PERIPHS];

    logic [7:0]           r_cmp [N_EVT_CMP];
    logic [N_EVT_CMP-1:0] r_mask;
    logic [N_EVT_CMP-1:0] r_status;
    logic [N_EVT_CMP-1:0] hit;
    logic [N_EVT_CMP-1:0] status_clr;
    logic [N_EVT_CMP-1:0] status_next;
    logic                 r_irq;

    logic       wr;
    logic       rd;
    logic [4:0] evt_word;
    logic       cfg_evt_sel;

    assign wr          = cfg_valid_i & ~cfg_rwn_i;
    assign rd          = cfg_valid_i & cfg_rwn_i;
    assign evt_word    = cfg_addr_i - ADDR_CFG_EVT;
    assign cfg_evt_sel = (cfg_addr_i >= ADDR_CFG_EVT) && (evt_word < 5'(N_CFG_WORDS));

    assign cfg_ready_o   = 1'b1;
    assign event_ready_o = 1'b1;

    always_comb begin
        for (int unsigned i = 0; i < N_PERIPHS; i++) begin
            busy[i] = (cnt[i] != 8'd0);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_EVT_CMP; k++) begin
            hit[k] = event_valid_i && (event_data_i == r_cmp[k]) && r_mask[k];
        end
    end

    // Only bits actually returned by the read are cleared; a coincident hit re-sets them.
    assign status_clr  = (rd && cfg_addr_i == ADDR_EVT_STATUS) ? r_status : '0;
    assign status_next = (r_status & ~status_clr) | hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cg     <= '0;
            r_rst    <= '0;
            r_mask   <= '1;
            r_status <= '0;
            r_irq    <= 1'b0;
            event_o  <= '0;
            for (int unsigned i = 0; i < N_PERIPHS; i++) begin
                cnt[i] <= '0;
            end
            for (int unsigned k = 0; k < N_EVT_CMP; k++) begin
                r_cmp[k] <= '0;
            end
        end else begin
            if (wr) begin
                case (cfg_addr_i)
                    ADDR_CG:       r_cg   <= cfg_data_i[N_PERIPHS-1:0];
                    ADDR_CG_SET:   r_cg   <= r_cg | cfg_data_i[N_PERIPHS-1:0];
                    ADDR_CG_CLR:   r_cg   <= r_cg & ~cfg_data_i[N_PERIPHS-1:0];
                    ADDR_RST:      r_rst  <= cfg_data_i[N_PERIPHS-1:0];
                    ADDR_EVT_MASK: r_mask <= cfg_data_i[N_EVT_CMP-1:0];
                    default: ;
                endcase
            end
            if (wr && cfg_evt_sel) begin
                for (int unsigned k = 0; k < N_EVT_CMP; k++) begin
                    if (5'(k / 4) == evt_word) begin
                        r_cmp[k] <= cfg_data_i[8*(k%4) +: 8];
                    end
                end
            end
            for (int unsigned i = 0; i < N_PERIPHS; i++) begin
                if (wr && cfg_addr_i == ADDR_RST_PULSE && cfg_data_i[i]) begin
                    cnt[i] <= 8'(RST_LEN);
                end else if (cnt[i] != 8'd0) begin
                    cnt[i] <= cnt[i] - 8'd1;
                end
            end
            event_o  <= hit;
            r_status <= status_next;
            r_irq    <= |status_next;
        end
    end

    assign rst_value_o = r_rst | busy;
    assign cg_value_o  = r_cg | busy;
    assign cg_core_o   = |cg_value_o;
    assign evt_irq_o   = r_irq;

    always_comb begin
        cfg_data_o = '0;
        case (cfg_addr_i)
            ADDR_CG, ADDR_CG_SET, ADDR_CG_CLR: cfg_data_o[N_PERIPHS-1:0] = r_cg;
            ADDR_RST:                          cfg_data_o[N_PERIPHS-1:0] = r_rst;
            ADDR_RST_PULSE:                    cfg_data_o[N_PERIPHS-1:0] = busy;
            ADDR_EVT_STATUS:                   cfg_data_o[N_EVT_CMP-1:0] = r_status;
            ADDR_EVT_MASK:                     cfg_data_o[N_EVT_CMP-1:0] = r_mask;
            default: begin
                if (cfg_evt_sel) begin
                    for (int unsigned k = 0; k < N_EVT_CMP; k++) begin
                        if (5'(k / 4) == evt_word) begin
                            cfg_data_o[8*(k%4) +: 8] = r_cmp[k];
                        end
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_udma_ctrl_evt_mc.sv
// Bench for udma_ctrl_evt_mc: directed literal checks plus randomized traffic
// against a time-based behavioural model compared every cycle.
module tb_udma_ctrl_evt_mc;

    localparam int NP = 6;
    localparam int NE = 4;
    localparam int RL = 8;

    logic          clk;
    logic          rst;
    logic [31:0]   cfg_wdata;
    logic [4:0]    cfg_addr;
    logic          cfg_valid;
    logic          cfg_rwn;
    logic [31:0]   cfg_rdata;
    logic          cfg_ready;
    logic [NP-1:0] rst_value;
    logic [NP-1:0] cg_value;
    logic          cg_core;
    logic          ev_valid;
    logic [7:0]    ev_data;
    logic          ev_ready;
    logic [NE-1:0] evt;
    logic          irq;

    udma_ctrl_evt_mc #(.N_PERIPHS(NP), .N_EVT_CMP(NE), .RST_LEN(RL)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_data_i(cfg_wdata), .cfg_addr_i(cfg_addr), .cfg_valid_i(cfg_valid),
        .cfg_rwn_i(cfg_rwn), .cfg_data_o(cfg_rdata), .cfg_ready_o(cfg_ready),
        .rst_value_o(rst_value), .cg_value_o(cg_value), .cg_core_o(cg_core),
        .event_valid_i(ev_valid), .event_data_i(ev_data), .event_ready_o(ev_ready),
        .event_o(evt), .evt_irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pulse resets tracked as absolute end times.
    int            cyc = 0;
    bit            model_ok = 0;
    logic [NP-1:0] m_cg, m_rst;
    int            m_end [NP];
    logic [7:0]    m_cmp [NE];
    logic [NE-1:0] m_mask, m_status, m_evt;
    logic [31:0]   exp_rd;
    bit            rd_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] m_busy();
        logic [NP-1:0] b;
        for (int i = 0; i < NP; i++) b[i] = (cyc < m_end[i]);
        return b;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            5'd0, 5'd1, 5'd2: r[NP-1:0] = m_cg;
            5'd3:             r[NP-1:0] = m_rst;
            5'd4:             r[NP-1:0] = m_busy();
            5'd5:             r[NE-1:0] = m_status;
            5'd6:             r[NE-1:0] = m_mask;
            default: begin
                if (a >= 5'd8 && int'(a) - 8 < NE / 4)
                    for (int k = 0; k < 4; k++) r[8*k +: 8] = m_cmp[(int'(a) - 8) * 4 + k];
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (model_ok) begin
            logic [NP-1:0] b;
            b = m_busy();
            chk("rst_value", 32'(rst_value), 32'(m_rst | b));
            chk("cg_value", 32'(cg_value), 32'(m_cg | b));
            chk("cg_core", 32'(cg_core), 32'(|(m_cg | b)));
            chk("event_o", 32'(evt), 32'(m_evt));
            chk("evt_irq", 32'(irq), 32'(|m_status));
            chk("ready", {30'd0, cfg_ready, ev_ready}, 32'd3);
            if (rd_chk) chk("cfg_rdata", cfg_rdata, exp_rd);
        end
    end

    task automatic begin_cycle(input logic v, input logic rwn, input logic [4:0] a,
                               input logic [31:0] d, input logic ev, input logic [7:0] ed,
                               input logic r);
        cfg_valid = v; cfg_rwn = rwn; cfg_addr = a; cfg_wdata = d;
        ev_valid = ev; ev_data = ed; rst = r;
        exp_rd = m_read(a);
        rd_chk = v & rwn;
    endtask

    task automatic end_cycle();
        logic [NE-1:0] hit, clr;
        logic [NP-1:0] n_cg, n_rst;
        logic [NE-1:0] n_mask;
        bit w;
        int wi;
        for (int k = 0; k < NE; k++) hit[k] = ev_valid && ev_data == m_cmp[k] && m_mask[k];
        clr = (cfg_valid && cfg_rwn && cfg_addr == 5'd5) ? m_status : '0;
        w = cfg_valid && !cfg_rwn;
        n_cg = m_cg; n_rst = m_rst; n_mask = m_mask;
        if (w) begin
            case (cfg_addr)
                5'd0: n_cg = cfg_wdata[NP-1:0];
                5'd1: n_cg = m_cg | cfg_wdata[NP-1:0];
                5'd2: n_cg = m_cg & ~cfg_wdata[NP-1:0];
                5'd3: n_rst = cfg_wdata[NP-1:0];
                5'd6: n_mask = cfg_wdata[NE-1:0];
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_cg = '0; m_rst = '0; m_mask = '1; m_status = '0; m_evt = '0;
            for (int i = 0; i < NP; i++) m_end[i] = 0;
            for (int k = 0; k < NE; k++) m_cmp[k] = 8'h00;
            model_ok = 1;
        end else begin
            if (w && cfg_addr == 5'd4)
                for (int i = 0; i < NP; i++) if (cfg_wdata[i]) m_end[i] = cyc + 1 + RL;
            if (w && cfg_addr >= 5'd8 && int'(cfg_addr) - 8 < NE / 4) begin
                wi = int'(cfg_addr) - 8;
                for (int k = 0; k < 4; k++) m_cmp[wi * 4 + k] = cfg_wdata[8*k +: 8];
            end
            m_cg = n_cg; m_rst = n_rst; m_mask = n_mask;
            m_status = (m_status & ~clr) | hit;
            m_evt = hit;
        end
        cyc++;
    endtask

    task automatic run(input logic v, input logic rwn, input logic [4:0] a, input logic [31:0] d,
                       input logic ev, input logic [7:0] ed, input logic r);
        begin_cycle(v, rwn, a, d, ev, ed, r);
        end_cycle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        run(1, 0, a, d, 0, 8'h00, 0);
    endtask

    task automatic ev(input logic [7:0] id);
        run(0, 0, 5'd0, 32'd0, 1, id, 0);
    endtask

    task automatic idle();
        run(0, 0, 5'd0, 32'd0, 0, 8'h00, 0);
    endtask

    task automatic idle_neg();
        begin_cycle(0, 0, 5'd0, 32'd0, 0, 8'h00, 0);
        @(negedge clk);
    endtask

    task automatic rd_lit(input string nm, input logic [4:0] a, input logic [31:0] lit);
        begin_cycle(1, 1, a, $urandom, 0, 8'h00, 0);
        @(negedge clk);
        chk(nm, cfg_rdata, lit);
        end_cycle();
    endtask

    initial begin
        int hi;
        logic [4:0] addr_tab [12];
        addr_tab = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd5, 5'd5, 5'd6, 5'd8, 5'd9, 5'd31};

        run(0, 0, 5'd0, 32'd0, 0, 8'h00, 1);
        run(0, 0, 5'd0, 32'd0, 1, 8'h00, 1);

        // Reset state
        rd_lit("rd_cg_rst", 5'd0, 32'h0);
        rd_lit("rd_rst_rst", 5'd3, 32'h0);
        rd_lit("rd_pulse_rst", 5'd4, 32'h0);
        rd_lit("rd_status_rst", 5'd5, 32'h0);
        rd_lit("rd_mask_rst", 5'd6, 32'hF);
        rd_lit("rd_cfgevt_rst", 5'd8, 32'h0);
        idle_neg();
        chk("outs_rst", {rst_value, cg_value, cg_core, evt, irq}, 32'h0);
        end_cycle();

        // Clock gate set/clear
        wr(5'd0, 32'h05); rd_lit("cg_load", 5'd0, 32'h05);
        wr(5'd1, 32'h02); rd_lit("cg_set", 5'd1, 32'h07);
        wr(5'd2, 32'h04); rd_lit("cg_clr", 5'd2, 32'h03);
        idle_neg(); chk("cg_core_on", 32'(cg_core), 32'd1); end_cycle();
        wr(5'd2, 32'h03);
        idle_neg(); chk("cg_core_off", 32'(cg_core), 32'd0); end_cycle();

        // Pulse reset length and mid-pulse busy read
        wr(5'd4, 32'h01);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                begin_cycle(1, 1, 5'd4, 32'd0, 0, 8'h00, 0);
                @(negedge clk);
                chk("pulse_busy_rd", cfg_rdata, 32'h01);
            end else begin
                idle_neg();
            end
            chk("pulse_rst", 32'(rst_value[0]), 32'(i < RL));
            chk("pulse_cg", 32'(cg_value[0]), 32'(i < RL));
            end_cycle();
        end
        // Rewrite in 5th pulse cycle restarts the count
        wr(5'd4, 32'h01);
        hi = 0;
        for (int i = 0; i < 4; i++) begin idle_neg(); hi += int'(rst_value[0]); end_cycle(); end
        begin_cycle(1, 0, 5'd4, 32'h01, 0, 8'h00, 0);
        @(negedge clk); hi += int'(rst_value[0]); end_cycle();
        for (int i = 0; i < 15; i++) begin idle_neg(); hi += int'(rst_value[0]); end_cycle(); end
        chk("pulse_restart_len", 32'(hi), 32'd13);

        // Event compare, status read-clear, irq
        wr(5'd8, 32'h44332211);
        ev(8'h33);
        idle_neg(); chk("evt_hit", 32'(evt), 32'h4); chk("irq_set", 32'(irq), 32'd1); end_cycle();
        idle_neg(); chk("evt_one_cycle", 32'(evt), 32'h0); end_cycle();
        rd_lit("status_rd", 5'd5, 32'h4);
        idle_neg(); chk("irq_clr", 32'(irq), 32'd0); end_cycle();
        rd_lit("status_rd2", 5'd5, 32'h0);

        // Masking
        wr(5'd6, 32'hB);
        ev(8'h33);
        idle_neg(); chk("evt_masked", 32'(evt), 32'h0); end_cycle();
        rd_lit("status_masked", 5'd5, 32'h0);
        wr(5'd8, 32'h11111111);
        ev(8'h11);
        idle_neg(); chk("evt_multi", 32'(evt), 32'hB); end_cycle();

        // Read-clear coinciding with hit: set wins
        begin_cycle(1, 1, 5'd5, 32'd0, 1, 8'h11, 0);
        @(negedge clk); chk("status_rd_hit", cfg_rdata, 32'hB); end_cycle();
        rd_lit("status_kept", 5'd5, 32'hB);
        rd_lit("status_cleared", 5'd5, 32'h0);

        // Out-of-range CFG_EVT word and unmapped address
        wr(5'd9, 32'hDEADBEEF);
        rd_lit("cfgevt_oob", 5'd9, 32'h0);
        rd_lit("unmapped", 5'd7, 32'h0);
        rd_lit("cfgevt_w0", 5'd8, 32'h11111111);

        // Reset mid-pulse and mid-event
        wr(5'd4, 32'h3F);
        idle(); idle();
        run(0, 0, 5'd0, 32'd0, 1, 8'h11, 1);
        idle_neg();
        chk("rst_mid_pulse", 32'(rst_value), 32'h0);
        chk("rst_mid_evt", 32'(evt), 32'h0);
        end_cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  a;
            logic [31:0] d;
            logic [7:0]  id;
            a = addr_tab[$urandom_range(0, 11)];
            d = $urandom;
            if (a == 5'd4) d = d & $urandom & $urandom;
            id = ($urandom_range(0, 9) < 7) ? m_cmp[$urandom_range(0, NE - 1)] : 8'($urandom);
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
                1'($urandom_range(0, 1)), id, 1'($urandom_range(0, 299) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udma_ctrl_evt_mc.md
Name: udma_ctrl_evt_mc

Overview:
Next-generation uDMA control/configuration block. It holds per-peripheral clock gates, with atomic set/clear, and per-peripheral resets, both level and self-timed pulse. It also provides a parametrised number of event-compare channels with masking, registered event outputs, sticky read-to-clear status and an aggregate interrupt. It sits on the uDMA config bus beside the channel arbiters and drives peripheral clock-gate and reset lines plus the SoC event outputs.

Parameters:
N_PERIPHS, 6, number of peripherals; 1..32
N_EVT_CMP, 4, number of event-compare channels; one of 4, 8, 12, 16
RST_LEN, 8, cycles a pulse reset is held; 1..255

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
cfg_data_i  in  32  config write data
cfg_addr_i  in  5  config word address
cfg_valid_i  in  1  config access valid
cfg_rwn_i  in  1  1=read, 0=write
cfg_data_o  out  32  config read data (combinational)
cfg_ready_o  out  1  tied 1
rst_value_o  out  N_PERIPHS  peripheral reset, active high
cg_value_o  out  N_PERIPHS  peripheral clock enable
cg_core_o  out  1  uDMA core clock enable
event_valid_i  in  1  incoming event strobe
event_data_i  in  8  incoming event id
event_ready_o  out  1  tied 1
event_o  out  N_EVT_CMP  per-channel matched event pulse
evt_irq_o  out  1  any sticky status bit set

Behaviour:
- One clock (clk_i). rst_i is synchronous and active-high: on a posedge of clk_i with rst_i=1, all state resets.
- Reset values:
  - r_cg=0, r_rst=0, pulse counters=0.
  - r_cmp all 0; r_mask all 1; r_status=0; event_o=0.
  - Resulting outputs: rst_value_o=0, cg_value_o=0, cg_core_o=0, evt_irq_o=0.
- Config access: a write is cfg_valid_i & ~cfg_rwn_i, taking effect at the next edge. A read is cfg_valid_i & cfg_rwn_i, with data valid the same cycle. No wait states.
- Register map (word addr):
  - 0x00 CG rw: write loads r_cg.
  - 0x01 CG_SET wo: r_cg |= data.
  - 0x02 CG_CLR wo: r_cg &= ~data.
  - 0x03 RST rw: level reset, write loads r_rst.
  - 0x04 RST_PULSE: for each write bit i=1, load cnt[i]=RST_LEN; bits written 0 are unaffected. Read returns busy bits (cnt!=0).
  - 0x05 EVT_STATUS: read returns r_status and clears the returned bits at the next edge. Writes are ignored.
  - 0x06 EVT_MASK rw, bits [N_EVT_CMP-1:0].
  - 0x08+w CFG_EVT word w, for w < N_EVT_CMP/4: bytes [8j+7:8j] = compare id of channel 4w+j.
- Reads of CG_SET/CG_CLR return r_cg. Reads of unmapped addresses, or of CFG_EVT words beyond N_EVT_CMP/4, return 0. Writes to them are ignored. Unused upper data bits read 0.
- Pulse counters:
  - cnt[i] decrements by 1 each cycle while nonzero.
  - A rewrite while busy reloads RST_LEN (restart, no accumulation).
- Output equations:
  - rst_value_o[i] = r_rst[i] | (cnt[i]!=0). The pulse lasts exactly RST_LEN cycles, starting the cycle after the write.
  - cg_value_o[i] = r_cg[i] | (cnt[i]!=0). The clock is forced on during a pulse so the peripheral samples its synchronous reset.
  - cg_core_o = |cg_value_o.
- Event compare:
  - hit[k] = event_valid_i & (event_data_i == r_cmp[k]) & r_mask[k].
  - event_o[k] <= hit[k]: one-cycle registered latency, one-cycle pulse per matching strobe.
  - Multiple channels may fire on the same event.
- Status: r_status[k] sets on hit[k].
  - A read-clear coinciding with a new hit leaves the bit at 1 (set wins), so the event is not lost.
  - evt_irq_o = |r_status, registered.
- Masking a channel stops new hits only; status already set stays until read.
- Writing CFG_EVT or EVT_MASK takes effect for events from the following cycle. An event in the write cycle uses the old values.
- rst_i asserted mid-pulse or mid-event clears counters and event_o on that edge.

Test Plan:
1. Reset, then read all registers -> CG/RST/STATUS/CFG_EVT read 0, EVT_MASK reads 0xF (N_EVT_CMP=4); all outputs 0.
2. Write CG=0x05, CG_SET=0x02, CG_CLR=0x04 -> reads 0x05, 0x07, 0x03; cg_core_o=1; CG_CLR=0x03 -> cg_core_o=0.
3. RST_LEN=8: write RST_PULSE=0x01 -> rst_value_o[0]=1 and cg_value_o[0]=1 for exactly 8 cycles. Rewrite at cycle 5 -> 13 cycles total. Read RST_PULSE mid-pulse returns 0x01.
4. CFG_EVT=0x44332211, event 0x33 -> event_o=0x4 one cycle later for one cycle; STATUS read 0x4, next read 0x0; evt_irq_o 1 then 0.
5. EVT_MASK=0xB, event 0x33 -> no event_o, status unchanged. CFG_EVT=0x11111111, event 0x11 -> event_o=0xB.
6. Event 0x11 hit in the same cycle as an EVT_STATUS read -> read returns the prior value, bit 0 remains 1 afterwards. rst_i asserted during a pulse -> rst_value_o=0 the next cycle.
